instruction_pointer_unit: RTL

Fetch-stage sequencer that generates the instruction address driven into the instruction ROM. It holds the program counter and applies sequential increment, absolute jump/branch, CALL and RET from the decode stage. It also owns a hardware return-address stack. The ROM word addressed by oIP is combinational, so decode sees the instruction in the same cycle oIP changes.

---
 rtl/instruction_pointer_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instruction_pointer_unit.sv
// Fetch-stage instruction pointer with hardware return-address stack.
// Build option: define IPU_IDLE_LOOP_DETECT_EN to add self-jump detection.
//
// Ports:
//   Clock           rising-edge system clock
//   Reset           synchronous, active-high; returns to RUN, clears flags
//   iStall          hold oIP and stack this cycle (requests dropped)
//   iJump           load oIP with iTarget
//   iCall           push oIP+1, load oIP with iTarget
//   iRet            load oIP with popped return address
//   iTarget         jump/call target address
//   oIP             current instruction address to ROM
//   oHalted         fault halt active (stack overflow/underflow)
//   oStackOverflow  sticky: CALL attempted with stack full
//   oStackUnderflow sticky: RET attempted with stack empty
//   oStackCount     number of entries on the return stack
//   oIdleLoop       sticky self-jump flag (0 when feature not built)
module instruction_pointer_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iStall,
    input  logic                           iJump,
    input  logic                           iCall,
    input  logic                           iRet,
    input  logic [ADDR_W-1:0]              iTarget,
    output logic [ADDR_W-1:0]              oIP,
    output logic                           oHalted,
    output logic                           oStackOverflow,
    output logic                           oStackUnderflow,
    output logic [$clog2(STACK_DEPTH):0]   oStackCount,
    output logic                           oIdleLoop
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] ip;
    logic [ADDR_W-1:0] ip_inc;
    logic [CNT_W-1:0]  count;
    logic              halted;
    logic              overflow;
    logic              underflow;
    logic              active;
    logic              do_call;
    logic              do_push;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  pop_idx;

    // RET outranks CALL, so a call only counts when no return is requested.
    assign active   = (state == RUN) && !iStall;
    assign do_call  = active && !iRet && iCall;
    assign do_push  = !Reset && do_call && (count != FULL);
    assign ip_inc   = ip + ADDR_W'(1);
    assign push_idx = count[PTR_W-1:0];
    assign pop_idx  = PTR_W'(count - CNT_W'(1));

    // Entries are never reset; only the valid region below count is read.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            stack[push_idx] <= ip_inc;
        end
    end

`ifdef IPU_IDLE_LOOP_DETECT_EN
    logic idle_loop;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= RUN;
            ip        <= RESET_ADDR;
            count     <= '0;
            halted    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef IPU_IDLE_LOOP_DETECT_EN
            idle_loop <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (iStall) begin
                        // requests this cycle are dropped
                    end else if (iRet) begin
                        if (count != '0) begin
                            ip    <= stack[pop_idx];
                            count <= count - CNT_W'(1);
                        end else begin
                            underflow <= 1'b1;
                            halted    <= 1'b1;
                            state     <= HALT;
                        end
                    end else if (iCall) begin
                        if (count != FULL) begin
                            ip    <= iTarget;
                            count <= count + CNT_W'(1);
                        end else begin
                            overflow <= 1'b1;
                            halted   <= 1'b1;
                            state    <= HALT;
                        end
                    end else if (iJump) begin
`ifdef IPU_IDLE_LOOP_DETECT_EN
                        if (iTarget == ip) begin
                            idle_loop <= 1'b1;
                        end
`endif
                        ip <= iTarget;
                    end else begin
                        ip <= ip_inc;
                    end
                end
                HALT: begin
                    // frozen until Reset
                end
                default: state <= HALT;
            endcase
        end
    end

    assign oIP             = ip;
    assign oHalted         = halted;
    assign oStackOverflow  = overflow;
    assign oStackUnderflow = underflow;
    assign oStackCount     = count;

`ifdef IPU_IDLE_LOOP_DETECT_EN
    assign oIdleLoop = idle_loop;
`else
    assign oIdleLoop = 1'b0;
`endif

endmodule
